// File: rtl/fifo_rd_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_arbiter_if
//  Description : Bundles the FIFO read-port signals and the per-consumer
//                request/grant/data signals of fifo_rd_arbiter.
//                modport master : the arbiter itself (drives inc/grant/data)
//                modport slave  : FIFO read logic plus the consumers
//  Signals     : i_empty  - registered FIFO empty flag
//                i_rdData - FIFO head word
//                i_req    - per-consumer request (level)
//                i_ready  - per-consumer accept
//                o_inc    - pop strobe to the FIFO read pointer
//                o_gnt    - one-hot grant (registered)
//                o_gntIdx - index of the granted consumer
//                o_valid  - o_data valid for the granted consumer
//                o_data   - pass-through of i_rdData
//                o_busy   - arbiter is serving a burst
//  Revision    : 1.0 - initial release
// ============================================================================
interface fifo_rd_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    localparam int c_IDX_W = $clog2(N_REQ);

    logic                 i_empty;
    logic [DATA_W-1:0]    i_rdData;
    logic [N_REQ-1:0]     i_req;
    logic [N_REQ-1:0]     i_ready;
    logic                 o_inc;
    logic [N_REQ-1:0]     o_gnt;
    logic [c_IDX_W-1:0]   o_gntIdx;
    logic                 o_valid;
    logic [DATA_W-1:0]    o_data;
    logic                 o_busy;

    modport master (
        input  i_empty, i_rdData, i_req, i_ready,
        output o_inc, o_gnt, o_gntIdx, o_valid, o_data, o_busy
    );

    modport slave (
        output i_empty, i_rdData, i_req, i_ready,
        input  o_inc, o_gnt, o_gntIdx, o_valid, o_data, o_busy
    );
endinterface
`default_nettype wire

// File: rtl/fifo_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_arbiter
//  Description : Read-clock-domain scheduler sharing the single read port of
//                an async FIFO among N_REQ consumers. Round-robin grant, up to
//                BURST_LEN words streamed per grant. Drives the read-pointer
//                increment and consumes the registered empty flag.
//  Ports       : i_clk - read-domain clock
//                i_rst - asynchronous, active-high reset
//                bus   - fifo_rd_arbiter_if.master (FIFO read port, consumer
//                        request/ready, grant/valid/data/busy outputs)
//  Options     : FIFO_RD_ARB_TIMEOUT_EN - when defined, a stall counter
//                releases the grant after TIMEOUT consecutive beat-less
//                burst cycles; when undefined the grant is held for as long
//                as the granted consumer keeps requesting.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    fifo_rd_arbiter_if.master bus
);

    localparam int c_IDX_W  = $clog2(N_REQ);
    localparam int c_BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(BURST_LEN - 1);
    // Pointer starts on the last consumer so consumer 0 wins first.
    localparam logic [c_IDX_W-1:0]  c_LAST_INIT = c_IDX_W'(N_REQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // Elaboration-time parameter sanity checks.
    if (N_REQ < 2) begin : g_chk_nreq
        $error("fifo_rd_arbiter: N_REQ must be >= 2");
    end
    if (BURST_LEN < 1) begin : g_chk_burst
        $error("fifo_rd_arbiter: BURST_LEN must be >= 1");
    end
    if (TIMEOUT < 1) begin : g_chk_timeout
        $error("fifo_rd_arbiter: TIMEOUT must be >= 1");
    end

    state_t               r_state;
    state_t               w_state_nxt;
    logic [N_REQ-1:0]     r_gnt;
    logic [N_REQ-1:0]     w_gnt_nxt;
    logic [c_IDX_W-1:0]   r_gnt_idx;
    logic [c_IDX_W-1:0]   w_gnt_idx_nxt;
    logic [c_IDX_W-1:0]   r_last;
    logic [c_IDX_W-1:0]   w_last_nxt;
    logic [c_BEAT_W-1:0]  r_beat;
    logic [c_BEAT_W-1:0]  w_beat_nxt;

    logic                 w_valid;
    logic                 w_inc;
    logic                 w_found;
    logic [c_IDX_W-1:0]   w_winner;

`ifdef FIFO_RD_ARB_TIMEOUT_EN
    localparam int c_STALL_W = $clog2(TIMEOUT + 1);
    // Release is scheduled on the TIMEOUT-th consecutive stall cycle.
    localparam logic [c_STALL_W-1:0] c_STALL_LAST = c_STALL_W'(TIMEOUT - 1);

    logic [c_STALL_W-1:0] r_stall;
    logic [c_STALL_W-1:0] w_stall_nxt;
`endif

    // ------------------------------------------------------------------------
    // Round-robin pick: first set request searching upward from last+1.
    // The loop walks offsets from farthest to nearest so the nearest match
    // is the one that sticks. Returns {found, index}.
    // ------------------------------------------------------------------------
    function automatic logic [c_IDX_W:0] rr_pick(
        input logic [N_REQ-1:0]   req,
        input logic [c_IDX_W-1:0] last
    );
        logic [c_IDX_W:0]   res;
        logic [c_IDX_W-1:0] cand;
        res = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = c_IDX_W'((int'(last) + k) % N_REQ);
            if (req[cand]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

    always_comb begin
        {w_found, w_winner} = rr_pick(bus.i_req, r_last);
    end

    // ------------------------------------------------------------------------
    // Combinational beat handshake. Gating valid with !i_empty guarantees the
    // FIFO is never popped while empty.
    // ------------------------------------------------------------------------
    assign w_valid = (r_state == ST_BURST) && !bus.i_empty;
    assign w_inc   = w_valid && bus.i_ready[r_gnt_idx];

    assign bus.o_valid  = w_valid;
    assign bus.o_inc    = w_inc;
    assign bus.o_gnt    = r_gnt;
    assign bus.o_gntIdx = r_gnt_idx;
    assign bus.o_data   = bus.i_rdData;
    assign bus.o_busy   = (r_state == ST_BURST);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_gnt_idx <= '0;
            r_last    <= c_LAST_INIT;
            r_beat    <= '0;
`ifdef FIFO_RD_ARB_TIMEOUT_EN
            r_stall   <= '0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_idx <= w_gnt_idx_nxt;
            r_last    <= w_last_nxt;
            r_beat    <= w_beat_nxt;
`ifdef FIFO_RD_ARB_TIMEOUT_EN
            r_stall   <= w_stall_nxt;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_gnt_idx_nxt = r_gnt_idx;
        w_last_nxt    = r_last;
        w_beat_nxt    = r_beat;
`ifdef FIFO_RD_ARB_TIMEOUT_EN
        w_stall_nxt   = r_stall;
`endif

        case (r_state)
            ST_IDLE: begin
                // Grants only from IDLE, which forces at least one idle cycle
                // between bursts and a fresh arbitration every time.
                if (w_found && !bus.i_empty) begin
                    w_state_nxt   = ST_BURST;
                    w_gnt_nxt     = N_REQ'(1) << w_winner;
                    w_gnt_idx_nxt = w_winner;
                    w_last_nxt    = w_winner;
                    w_beat_nxt    = '0;
`ifdef FIFO_RD_ARB_TIMEOUT_EN
                    w_stall_nxt   = '0;
`endif
                end
            end

            ST_BURST: begin
                if (w_inc) begin
                    // A beat always counts, even if the request dropped in the
                    // same cycle; release then happens on a later beat-less cycle.
                    w_beat_nxt = r_beat + c_BEAT_W'(1);
`ifdef FIFO_RD_ARB_TIMEOUT_EN
                    w_stall_nxt = '0;
`endif
                    if (r_beat == c_LAST_BEAT) begin
                        w_state_nxt = ST_IDLE;
                        w_gnt_nxt   = '0;
                        w_beat_nxt  = '0;
                    end
                end else if (!bus.i_req[r_gnt_idx]) begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = '0;
                    w_beat_nxt  = '0;
                end else begin
`ifdef FIFO_RD_ARB_TIMEOUT_EN
                    // Stalled on empty FIFO or a non-ready consumer.
                    if (r_stall == c_STALL_LAST) begin
                        w_state_nxt = ST_IDLE;
                        w_gnt_nxt   = '0;
                        w_beat_nxt  = '0;
                        w_stall_nxt = '0;
                    end else begin
                        w_stall_nxt = r_stall + c_STALL_W'(1);
                    end
`else
                    // Grant held: counter and grant unchanged while stalled.
                    w_state_nxt = ST_BURST;
`endif
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

endmodule
`default_nettype wire
